round_pipe: RTL and testbench

ROUND_PIPE -- requirements
Module: round_pipe

---
 rtl/round_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_round_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/round_pipe.sv
// round_pipe -- two-stage IEEE-754 style rounding and packing pipeline.
//
// Takes a normalised significand with guard/round/sticky bits, rounds it
// in one of four directed modes, and packs sign, biased exponent and
// fraction into a binary interchange word. Overflow saturates to Inf or
// to the largest finite value depending on the rounding direction.
// Subnormals are rounded in place or flushed to signed zero.
//
// Stage S1 registers the rounded significand (including its carry-out).
// Stage S2 registers the packed result and its exception flags.
// Valid/ready handshake on both sides, one beat per cycle.
//
// Optional feature: define ROUND_PIPE_STICKY_FLAGS_EN to build the
// accumulating sticky_flags register (cleared by flag_clr). Without the
// macro sticky_flags reads 000 and flag_clr is ignored.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/ready    input handshake
//   s_in              sign
//   exp_in            unbiased exponent, two's complement, EXP_W+2 bits
//   frac_in           {hidden, fraction, guard, round, sticky}
//   denorm_in         beat is subnormal (hidden bit expected 0)
//   zero_in           beat is an exact zero
//   nj_mode           flush subnormals to signed zero
//   rnd_mode          00 RNE, 01 RTZ, 10 RUP, 11 RDN
//   out_valid/ready   output handshake
//   res               packed {sign, exponent, fraction}
//   flags             {inexact, overflow, underflow} of the beat on res
//   sticky_flags      accumulated flags; flag_clr clears them
module round_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      s_in,
  input  logic [EXP_W+1:0]          exp_in,
  input  logic [FRAC_W+3:0]         frac_in,
  input  logic                      denorm_in,
  input  logic                      zero_in,
  input  logic                      nj_mode,
  input  logic [1:0]                rnd_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     res,
  output logic [2:0]                flags,
  output logic [2:0]                sticky_flags,
  input  logic                      flag_clr
);

  localparam int RES_W = EXP_W + FRAC_W + 1;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  // Exponent arithmetic is EXP_W+2 bits signed so that out-of-range
  // unbiased exponents cannot wrap into a valid-looking field.
  localparam logic signed [EXP_W+1:0] BIAS_V  = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [EXP_W+1:0] EXP_OVF = {2'b00, {EXP_W{1'b1}}};

  // ---------------------------------------------------------------- S1
  logic              s1_valid_q;
  logic              s1_sign_q;
  logic [EXP_W+1:0]  s1_exp_q;
  logic [FRAC_W+1:0] s1_sum_q;
  logic              s1_inexact_q;
  logic              s1_denorm_q;
  logic              s1_zero_q;
  logic              s1_nj_q;
  logic [1:0]        s1_rnd_q;

  logic              s2_valid_q;
  logic              s2_adv;

  logic [FRAC_W:0]   mant_in;
  logic              lsb_b, g_b, r_b, st_b, grs_any;
  logic              inc_d;
  logic [FRAC_W+1:0] sum_d;

  assign mant_in = frac_in[FRAC_W+3:3];
  assign lsb_b   = frac_in[3];
  assign g_b     = frac_in[2];
  assign r_b     = frac_in[1];
  assign st_b    = frac_in[0];
  assign grs_any = g_b | r_b | st_b;

  // NOTE: every signal assigned in always_comb gets a default first so a
  // missed case branch can never infer a latch.
  always_comb begin
    inc_d = 1'b0;
    case (rnd_mode)
      RM_RNE:  inc_d = g_b & (r_b | st_b | lsb_b);
      RM_RTZ:  inc_d = 1'b0;
      RM_RUP:  inc_d = ~s_in & grs_any;
      RM_RDN:  inc_d = s_in & grs_any;
      default: inc_d = 1'b0;
    endcase
  end

  // One extra bit on top of the significand captures the carry-out.
  assign sum_d = {1'b0, mant_in} + {{(FRAC_W+1){1'b0}}, inc_d};

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_adv;

  // NOTE: pipeline payload registers carry no reset; only the valid bits
  // (and the visible output word) need a defined value after reset.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_sign_q    <= s_in;
      s1_exp_q     <= exp_in;
      s1_sum_q     <= sum_d;
      s1_inexact_q <= grs_any;
      s1_denorm_q  <= denorm_in;
      s1_zero_q    <= zero_in;
      s1_nj_q      <= nj_mode;
      s1_rnd_q     <= rnd_mode;
    end
  end

  // ---------------------------------------------------------------- S2
  logic                    carry;
  logic signed [EXP_W+1:0] biased;
  logic                    ovf;
  logic                    to_inf;
  logic [RES_W-1:0]        res_d;
  logic [2:0]              flags_d;
  logic [RES_W-1:0]        res_q;
  logic [2:0]              flags_q;

  assign carry  = s1_sum_q[FRAC_W+1];
  assign biased = s1_exp_q + BIAS_V + {{(EXP_W+1){1'b0}}, carry};
  assign ovf    = biased >= EXP_OVF;
  assign to_inf = (s1_rnd_q == RM_RNE) ||
                  (s1_rnd_q == RM_RUP && !s1_sign_q) ||
                  (s1_rnd_q == RM_RDN && s1_sign_q);

  always_comb begin
    res_d   = '0;
    flags_d = 3'b000;
    if (s1_zero_q) begin
      res_d   = '0;
      flags_d = 3'b000;
    end else if (s1_denorm_q && s1_nj_q) begin
      res_d   = {s1_sign_q, {(RES_W-1){1'b0}}};
      flags_d = 3'b101;
    end else if (s1_denorm_q) begin
      // Rounding up into the hidden position promotes the subnormal to the
      // smallest normal: exponent field 1, fraction bits already zero.
      res_d   = {s1_sign_q, {(EXP_W-1){1'b0}}, s1_sum_q[FRAC_W],
                 s1_sum_q[FRAC_W-1:0]};
      flags_d = {s1_inexact_q, 1'b0, s1_inexact_q};
    end else if (ovf) begin
      res_d   = to_inf ? {s1_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                       : {s1_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
      flags_d = 3'b110;
    end else begin
      res_d   = {s1_sign_q, biased[EXP_W-1:0],
                 carry ? {FRAC_W{1'b0}} : s1_sum_q[FRAC_W-1:0]};
      flags_d = {s1_inexact_q, 2'b00};
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      flags_q    <= 3'b000;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          res_q   <= res_d;
          flags_q <= flags_d;
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign res       = res_q;
  assign flags     = flags_q;

  // ------------------------------------------------------- sticky flags
`ifdef ROUND_PIPE_STICKY_FLAGS_EN
  logic [2:0] sticky_q;
  logic       accept_out;

  assign accept_out = s2_valid_q & out_ready;

  // A clear coinciding with an accept keeps just that beat's flags, so no
  // exception is lost across the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 3'b000;
    end else if (flag_clr) begin
      sticky_q <= accept_out ? flags_q : 3'b000;
    end else if (accept_out) begin
      sticky_q <= sticky_q | flags_q;
    end
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;
  assign sticky_flags    = 3'b000;
`endif

endmodule

// File: tb/tb_round_pipe.sv
// Directed testbench for round_pipe (EXP_W=8, FRAC_W=23).
module tb_round_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        s_in;
  logic [9:0]  exp_in;
  logic [26:0] frac_in;
  logic        denorm_in;
  logic        zero_in;
  logic        nj_mode;
  logic [1:0]  rnd_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic [2:0]  flags;
  logic [2:0]  sticky_flags;
  logic        flag_clr;

  int errors = 0;
  int checks = 0;

  round_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .s_in         (s_in),
    .exp_in       (exp_in),
    .frac_in      (frac_in),
    .denorm_in    (denorm_in),
    .zero_in      (zero_in),
    .nj_mode      (nj_mode),
    .rnd_mode     (rnd_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .res          (res),
    .flags        (flags),
    .sticky_flags (sticky_flags),
    .flag_clr     (flag_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic set_beat(input logic s, input logic [9:0] e,
                          input logic [26:0] f, input logic dn,
                          input logic z, input logic nj,
                          input logic [1:0] rm);
    s_in      = s;
    exp_in    = e;
    frac_in   = f;
    denorm_in = dn;
    zero_in   = z;
    nj_mode   = nj;
    rnd_mode  = rm;
  endtask

  // Push one beat into an idle pipeline and check the result that emerges.
  task automatic run_beat(input string tag, input logic s,
                          input logic [9:0] e, input logic [26:0] f,
                          input logic dn, input logic z, input logic nj,
                          input logic [1:0] rm, input logic [31:0] er,
                          input logic [2:0] ef);
    int n;
    @(negedge clk);
    set_beat(s, e, f, dn, z, nj, rm);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 4) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, res, er);
    check({tag, "_flags"}, 32'(flags), 32'(ef));
  endtask

  initial begin
    logic [31:0] held;
    int acc, got, gaps, fire;
    logic [31:0] bp_exp [4];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
    set_beat(1'b0, 10'd0, 27'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res", res, 32'h0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_sticky", 32'(sticky_flags), 32'd0);

    // Rounding, carry, overflow, subnormal, flush and zero vectors.
    run_beat("rne_tie_even", 1'b0, 10'd0, 27'h4000004, 1'b0, 1'b0, 1'b0, 2'b00, 32'h3F800000, 3'b100);
    run_beat("rne_tie_odd",  1'b0, 10'd0, 27'h400000C, 1'b0, 1'b0, 1'b0, 2'b00, 32'h3F800002, 3'b100);
    run_beat("rne_carry",    1'b0, 10'd0, 27'h7FFFFFC, 1'b0, 1'b0, 1'b0, 2'b00, 32'h40000000, 3'b100);
    run_beat("rtz_carry",    1'b0, 10'd0, 27'h7FFFFFC, 1'b0, 1'b0, 1'b0, 2'b01, 32'h3FFFFFFF, 3'b100);
    run_beat("rdn_neg",      1'b1, 10'd0, 27'h4000001, 1'b0, 1'b0, 1'b0, 2'b11, 32'hBF800001, 3'b100);
    run_beat("rup_neg",      1'b1, 10'd0, 27'h4000001, 1'b0, 1'b0, 1'b0, 2'b10, 32'hBF800000, 3'b100);
    run_beat("ovf_rne",      1'b0, 10'd128, 27'h4000000, 1'b0, 1'b0, 1'b0, 2'b00, 32'h7F800000, 3'b110);
    run_beat("ovf_rtz",      1'b0, 10'd128, 27'h4000000, 1'b0, 1'b0, 1'b0, 2'b01, 32'h7F7FFFFF, 3'b110);
    run_beat("ovf_rup_neg",  1'b1, 10'd128, 27'h4000000, 1'b0, 1'b0, 1'b0, 2'b10, 32'hFF7FFFFF, 3'b110);
    run_beat("ovf_rdn_neg",  1'b1, 10'd128, 27'h4000000, 1'b0, 1'b0, 1'b0, 2'b11, 32'hFF800000, 3'b110);
    run_beat("sub_exact",    1'b0, 10'd0, 27'h0000008, 1'b1, 1'b0, 1'b0, 2'b00, 32'h00000001, 3'b000);
    run_beat("sub_promote",  1'b0, 10'd0, 27'h3FFFFFC, 1'b1, 1'b0, 1'b0, 2'b00, 32'h00800000, 3'b101);
    run_beat("flush_neg",    1'b1, 10'd0, 27'h4000000, 1'b1, 1'b0, 1'b1, 2'b00, 32'h80000000, 3'b101);
    run_beat("zero_neg",     1'b1, 10'd5, 27'h4000007, 1'b1, 1'b1, 1'b1, 2'b11, 32'h00000000, 3'b000);

`ifdef ROUND_PIPE_STICKY_FLAGS_EN
    check("sticky_accum", 32'(sticky_flags), 32'd7);
    @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    check("sticky_clr", 32'(sticky_flags), 32'd0);
`else
    check("sticky_tied", 32'(sticky_flags), 32'd0);
`endif

    // Backpressure: four beats, output stalled until two are held.
    for (int k = 0; k < 4; k++) bp_exp[k] = 32'h3F800000 + 32'(k + 1);
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      set_beat(1'b0, 10'd0, 27'h4000000 + 27'((acc + 1) << 3), 1'b0, 1'b0, 1'b0, 2'b00);
      in_valid = 1'b1;
      #1;
      fire = int'(in_valid & in_ready);
      @(posedge clk);
      acc += fire;
    end
    @(negedge clk);
    #1;
    check("bp_accepted", 32'(acc), 32'd2);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_head", res, bp_exp[0]);
    held = res;
    repeat (2) @(negedge clk);
    check("bp_res_stable", res, held);
    check("bp_flags_stable", 32'(flags), 32'd0);

    got = 0; gaps = 0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      if (c > 0) @(negedge clk);
      out_ready = 1'b1;
      if (acc < 4) begin
        set_beat(1'b0, 10'd0, 27'h4000000 + 27'((acc + 1) << 3), 1'b0, 1'b0, 1'b0, 2'b00);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        check("bp_order", res, bp_exp[got]);
        got++;
      end else begin
        gaps++;
      end
      fire = int'(in_valid & in_ready);
      @(posedge clk);
      acc += fire;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_count", 32'(got), 32'd4);
    check("bp_no_gaps", 32'(gaps), 32'd0);

    // Reset with both stages occupied discards everything.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_beat(1'b0, 10'd128, 27'h4000007, 1'b0, 1'b0, 1'b0, 2'b00);
      in_valid = 1'b1;
    end
    @(negedge clk);
    check("full_before_rst", 32'(out_valid), 32'd1);
    rst = 1'b1;
    flag_clr = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_full_out_valid", 32'(out_valid), 32'd0);
    check("rst_full_in_ready", 32'(in_ready), 32'd1);
    check("rst_full_res", res, 32'h0);
    check("rst_full_flags", 32'(flags), 32'd0);
    check("rst_full_sticky", 32'(sticky_flags), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_no_ghost", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
